// File: rtl/conv_result_packer.sv
// -----------------------------------------------------------------------------
// conv_result_packer
//
// Output-side companion of convolution_core. For every lane it sums the
// absolute values of the per-kernel signed results (e.g. Sobel |gx|+|gy|),
// shifts and saturates that sum to one PIX_WIDTH pixel, and packs the pixels
// back into a PORT_BITS word in the core's lane order. Words stream out of a
// first-word-fall-through FIFO over valid/ready, with end-of-frame marking.
//
// Ports
//   clk         rising-edge clock for all logic
//   rst         synchronous, active-high reset
//   in_data     [KERNEL_NUM][NUM_PER_CYCLE] signed OUT_WIDTH core results
//   in_vld      core result valid (the core cannot be back-pressured directly)
//   stall       request to deassert the core's clk_en
//   m_data      packed pixels, lane i at [(i+1)*PIX_WIDTH-1 -: PIX_WIDTH]
//   m_valid     output word valid
//   m_ready     downstream accept
//   m_last      high with the last word of a frame
//   frame_done  one-cycle pulse, registered, after the last word is accepted
//   overflow    sticky; set when a word is dropped on a full FIFO
// -----------------------------------------------------------------------------
module conv_result_packer #(
  parameter int ROI_SIZE   = 480,
  parameter int PORT_BITS  = 128,
  parameter int PIX_WIDTH  = 8,
  parameter int OUT_WIDTH  = 17,
  parameter int KERNEL_NUM = 2,
  parameter int SHIFT      = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                                               clk,
  input  logic                                                               rst,
  input  logic signed [KERNEL_NUM-1:0][PORT_BITS/PIX_WIDTH-1:0][OUT_WIDTH-1:0] in_data,
  input  logic                                                               in_vld,
  output logic                                                               stall,
  output logic [PORT_BITS-1:0]                                               m_data,
  output logic                                                               m_valid,
  input  logic                                                               m_ready,
  output logic                                                               m_last,
  output logic                                                               frame_done,
  output logic                                                               overflow
);

  localparam int NPC     = PORT_BITS / PIX_WIDTH;
  localparam int WPF     = ROI_SIZE * ROI_SIZE / NPC;
  localparam int ABS_W   = OUT_WIDTH + 1;  // holds |-2^(OUT_WIDTH-1)| exactly
  localparam int SUM_W   = OUT_WIDTH + 1 + $clog2(KERNEL_NUM);
  localparam int CNT_W   = (WPF > 1) ? $clog2(WPF) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
  localparam int PIX_MAX = (2 ** PIX_WIDTH) - 1;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WPF - 1);

  // Frame counter and pipeline stages
  logic [CNT_W-1:0]                r_word_cnt;
  logic                            r_s1_vld, r_s1_last;
  logic [NPC-1:0][SUM_W-1:0]       r_s1_sum;
  logic                            r_s2_vld, r_s2_last;
  logic [PORT_BITS-1:0]            r_s2_word;

  // FIFO: {last, data} per entry
  logic [PORT_BITS:0]              r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]                r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0]                r_count;
  logic                            r_frame_done;
  logic                            r_overflow;

  logic                            w_last;
  logic [NPC-1:0][SUM_W-1:0]       w_abs_sum;
  logic [NPC-1:0][PIX_WIDTH-1:0]   w_pix;
  logic [PORT_BITS:0]              w_head;
  logic                            w_full, w_pop, w_wr, w_drop;
  logic [OCC_W:0]                  w_occ;

  function automatic logic [ABS_W-1:0] abs_val(input logic [OUT_WIDTH-1:0] x);
    logic [ABS_W-1:0] ext;
    ext = {x[OUT_WIDTH-1], x};
    return ext[ABS_W-1] ? (~ext + ABS_W'(1)) : ext;
  endfunction

  function automatic logic [PIX_WIDTH-1:0] shift_sat(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] sh;
    sh = s >> SHIFT;
    return (sh > SUM_W'(PIX_MAX)) ? PIX_WIDTH'(PIX_MAX) : sh[PIX_WIDTH-1:0];
  endfunction

  // Stage 0: last flag is decided here so it can ride with the word.
  assign w_last = (r_word_cnt == LAST_IDX);

  always_comb begin
    // NOTE: assign a default before the loop so no path leaves the signal unassigned (no latch).
    w_abs_sum = '0;
    for (int l = 0; l < NPC; l++) begin
      for (int k = 0; k < KERNEL_NUM; k++) begin
        w_abs_sum[l] = w_abs_sum[l] + SUM_W'(abs_val(in_data[k][l]));
      end
    end
  end

  always_comb begin
    w_pix = '0;
    for (int l = 0; l < NPC; l++) begin
      w_pix[l] = shift_sat(r_s1_sum[l]);
    end
  end

  // FIFO control. A push onto a full FIFO is legal only when a pop frees a slot
  // in the same cycle; otherwise the word is dropped and overflow latches.
  assign m_valid = (r_count != '0);
  assign w_pop   = m_valid && m_ready;
  assign w_full  = (r_count == OCC_W'(FIFO_DEPTH));
  assign w_wr    = r_s2_vld && (!w_full || w_pop);
  assign w_drop  = r_s2_vld && w_full && !w_pop;

  assign w_head  = r_mem[r_rd_ptr];
  assign m_data  = m_valid ? w_head[PORT_BITS-1:0] : '0;
  assign m_last  = m_valid && w_head[PORT_BITS];

  // Occupancy counts words already committed to the pipeline, since the core
  // keeps producing for a couple of cycles after stall rises.
  assign w_occ = {1'b0, r_count} + (OCC_W + 1)'(r_s1_vld) + (OCC_W + 1)'(r_s2_vld);
  assign stall = (w_occ >= (OCC_W + 1)'(FIFO_DEPTH - 2));

  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_word_cnt   <= '0;
      r_s1_vld     <= 1'b0;
      r_s1_last    <= 1'b0;
      r_s2_vld     <= 1'b0;
      r_s2_last    <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      // Counts dropped words too, so framing stays aligned with the core.
      if (in_vld) begin
        r_word_cnt <= w_last ? '0 : r_word_cnt + CNT_W'(1);
      end
      r_s1_vld     <= in_vld;
      r_s1_last    <= in_vld && w_last;
      r_s2_vld     <= r_s1_vld;
      r_s2_last    <= r_s1_last;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count      <= r_count + OCC_W'(w_wr) - OCC_W'(w_pop);
      r_frame_done <= w_pop && m_last;
      r_overflow   <= r_overflow || w_drop;
    end
  end

  // Datapath registers carry no reset: their contents only matter when the
  // matching valid bit or FIFO count says so.
  always_ff @(posedge clk) begin
    r_s1_sum  <= w_abs_sum;
    r_s2_word <= w_pix;
    // NOTE: the FIFO storage is deliberately not reset; the pointers and count define what is live.
    if (w_wr && !rst) begin
      r_mem[r_wr_ptr] <= {r_s2_last, r_s2_word};
    end
  end

endmodule

// File: tb/tb_conv_result_packer.sv
// -----------------------------------------------------------------------------
// tb_conv_result_packer
//
// Drives two packers (SHIFT=0 and SHIFT=2) with identical stimulus. A
// reference model turns each accepted core word into expected pixels from the
// abs-sum / shift / saturate rules and tracks frame position, FIFO occupancy
// and drops; a monitor compares every presented output word against the
// expected-word queue.
// -----------------------------------------------------------------------------
module tb_conv_result_packer;

  localparam int ROI_SIZE   = 480;
  localparam int PORT_BITS  = 128;
  localparam int PIX_WIDTH  = 8;
  localparam int OUT_WIDTH  = 17;
  localparam int KERNEL_NUM = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int NPC        = PORT_BITS / PIX_WIDTH;
  localparam int WPF        = ROI_SIZE * ROI_SIZE / NPC;

  typedef logic [KERNEL_NUM-1:0][NPC-1:0][OUT_WIDTH-1:0] tb_data_t;

  typedef struct packed {
    logic [PORT_BITS-1:0] d0;
    logic [PORT_BITS-1:0] d2;
    logic                 last;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  tb_data_t             in_data;
  logic                 in_vld;
  logic                 m_ready;
  logic                 stall, m_valid, m_last, frame_done, overflow;
  logic [PORT_BITS-1:0] m_data;
  logic                 stall2, m_valid2, m_last2, frame_done2, overflow2;
  logic [PORT_BITS-1:0] m_data2;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  conv_result_packer #(
    .ROI_SIZE(ROI_SIZE), .PORT_BITS(PORT_BITS), .PIX_WIDTH(PIX_WIDTH), .OUT_WIDTH(OUT_WIDTH),
    .KERNEL_NUM(KERNEL_NUM), .SHIFT(0), .FIFO_DEPTH(FIFO_DEPTH)
  ) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .stall(stall),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .frame_done(frame_done), .overflow(overflow)
  );

  conv_result_packer #(
    .ROI_SIZE(ROI_SIZE), .PORT_BITS(PORT_BITS), .PIX_WIDTH(PIX_WIDTH), .OUT_WIDTH(OUT_WIDTH),
    .KERNEL_NUM(KERNEL_NUM), .SHIFT(2), .FIFO_DEPTH(FIFO_DEPTH)
  ) u_dut_sh2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .stall(stall2),
    .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready), .m_last(m_last2),
    .frame_done(frame_done2), .overflow(overflow2)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] sat8(input int s);
    return (s > 255) ? 8'hFF : s[7:0];
  endfunction

  function automatic exp_t make_exp(input tb_data_t d, input bit last);
    exp_t e;
    e.last = last;
    for (int i = 0; i < NPC; i++) begin
      int a;
      int b;
      int s;
      a = $signed(d[0][i]);
      b = $signed(d[1][i]);
      s = (a < 0 ? -a : a) + (b < 0 ? -b : b);
      e.d0[i*8 +: 8] = sat8(s);
      e.d2[i*8 +: 8] = sat8(s / 4);
    end
    return e;
  endfunction

  exp_t exp_q[$];
  exp_t p1, p2;
  bit   p1_v = 0, p2_v = 0;
  int   occ = 0;
  int   frame_idx = 0;
  bit   exp_ovf = 0;
  bit   mon_en = 0;
  bit   m_pop;

  // Each accepted core word reaches the FIFO two edges later; it is retained
  // unless the FIFO is full and nothing leaves on that edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      occ = 0; p1_v = 0; p2_v = 0; frame_idx = 0; exp_ovf = 0; mon_en = 1;
    end else begin
      m_pop = (occ > 0) && m_ready;
      if (p2_v) begin
        if (occ < FIFO_DEPTH || m_pop) begin
          exp_q.push_back(p2);
          occ++;
        end else begin
          exp_ovf = 1;
        end
      end
      if (m_pop) occ--;
      p2_v = p1_v;
      p2   = p1;
      p1_v = in_vld;
      if (in_vld) begin
        p1 = make_exp(in_data, frame_idx == WPF - 1);
        frame_idx = (frame_idx == WPF - 1) ? 0 : frame_idx + 1;
      end
    end
  end

  // ---------------- monitor ----------------
  exp_t head;
  bit   exp_v, exp_stall;
  bit   fd_pend = 0;
  int   fd_seen = 0, hs_cnt = 0, last_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_v     = (exp_q.size() != 0);
      exp_stall = (exp_q.size() + int'(p1_v) + int'(p2_v)) >= FIFO_DEPTH - 2;
      check("m_valid", m_valid, exp_v);
      check("m_valid_sh2", m_valid2, exp_v);
      check("stall", stall, exp_stall);
      check("stall_sh2", stall2, exp_stall);
      check("overflow", overflow, exp_ovf);
      check("overflow_sh2", overflow2, exp_ovf);
      check("frame_done", frame_done, fd_pend);
      check("frame_done_sh2", frame_done2, fd_pend);
      if (frame_done) fd_seen++;
      head = '0;
      if (exp_v) begin
        head = exp_q[0];
        check("m_data", m_data, head.d0);
        check("m_data_sh2", m_data2, head.d2);
        check("m_last", m_last, head.last);
        check("m_last_sh2", m_last2, head.last);
      end
      fd_pend = exp_v && m_ready && head.last && !rst;
      if (exp_v && m_ready) begin
        void'(exp_q.pop_front());
        hs_cnt++;
        if (head.last) last_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd_val();
    if ($urandom_range(0, 3) != 0) return int'($urandom_range(0, 400)) - 200;
    return int'($urandom_range(0, 131071)) - 65536;
  endfunction

  task automatic rand_data();
    for (int k = 0; k < KERNEL_NUM; k++)
      for (int i = 0; i < NPC; i++)
        in_data[k][i] = 17'(rnd_val());
  endtask

  task automatic set_lane(input int k, input int l, input int v);
    in_data[k][l] = 17'(v);
  endtask

  task automatic drain();
    in_vld  = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || p1_v || p2_v); i++) tick();
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_vld = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int hs_base, fd_base, last_base, sent, cyc;
    rst = 1'b1; in_vld = 1'b0; m_ready = 1'b0; in_data = '0;
    tick();

    // Reset held with in_vld high: everything stays at zero.
    for (int c = 0; c < 3; c++) begin
      rst = 1'b1; in_vld = 1'b1; rand_data();
      tick();
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_last", m_last, 0);
      check("rst_stall", stall, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_overflow", overflow, 0);
    end
    rst = 1'b0; in_vld = 1'b0;
    tick();

    // Arithmetic vectors and two-edge latency.
    m_ready = 1'b1;
    rand_data();
    set_lane(0, 0, 100);    set_lane(1, 0, -50);
    set_lane(0, 1, 200);    set_lane(1, 1, 100);
    set_lane(0, 2, -65536); set_lane(1, 2, -65536);
    set_lane(0, 3, 0);      set_lane(1, 3, 0);
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    check("lat_k", m_valid, 0);
    tick();
    check("lat_k1", m_valid, 0);
    tick();
    check("lat_k2", m_valid, 1);
    check("lane0", m_data[7:0], 8'h96);
    check("lane1", m_data[15:8], 8'hFF);
    check("lane2", m_data[23:16], 8'hFF);
    check("lane3", m_data[31:24], 8'h00);
    check("lane1_sh2", m_data2[15:8], 8'h4B);
    check("first_last", m_last, 0);
    tick();

    // Short random traffic honoring stall.
    for (int c = 0; c < 60; c++) begin
      m_ready = ($urandom_range(0, 1) != 0);
      in_vld  = !stall && ($urandom_range(0, 1) != 0);
      rand_data();
      tick();
    end
    drain();

    // Backpressure and overflow.
    m_ready = 1'b0;
    for (int w = 0; w < 6; w++) begin
      in_vld = 1'b1; rand_data();
      tick();
      if (w == 4) check("bp_stall_at5", stall, 0);
    end
    check("bp_stall_at6", stall, 1);
    for (int w = 0; w < 4; w++) begin
      in_vld = 1'b1; rand_data();
      tick();
    end
    in_vld = 1'b0;
    repeat (3) tick();
    check("bp_overflow", overflow, 1);
    hs_base = hs_cnt;
    drain();
    check("bp_retained", hs_cnt - hs_base, 8);

    // Simultaneous push and pop on a full FIFO.
    do_reset();
    m_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      m_ready = (c >= 10);
      in_vld = 1'b1; rand_data();
      tick();
      if (c == 10) check("full_count", m_valid, 1);
    end
    check("full_no_overflow", overflow, 0);
    drain();

    // One full frame plus the first word of the next.
    do_reset();
    fd_base = fd_seen; last_base = last_cnt;
    m_ready = 1'b1;
    for (int w = 0; w < WPF + 1; w++) begin
      in_vld = 1'b1; rand_data();
      tick();
    end
    drain();
    check("frame_done_count", fd_seen - fd_base, 1);
    check("frame_last_count", last_cnt - last_base, 1);

    // Reset mid-frame at word 5000, then a full frame under random backpressure.
    m_ready = 1'b1;
    for (int w = 0; w < 5000; w++) begin
      in_vld = 1'b1; rand_data();
      tick();
    end
    rst = 1'b1; in_vld = 1'b1; rand_data();
    tick();
    rst = 1'b0; in_vld = 1'b0;
    check("midrst_m_valid", m_valid, 0);
    fd_base = fd_seen; last_base = last_cnt;
    sent = 0; cyc = 0;
    while (sent < WPF + 1 && cyc < 60000) begin
      m_ready = ($urandom_range(0, 3) != 0);
      in_vld  = !stall && ($urandom_range(0, 3) != 0);
      rand_data();
      if (in_vld) sent++;
      tick();
      cyc++;
    end
    check("stream_bound", sent, WPF + 1);
    drain();
    check("frame2_done_count", fd_seen - fd_base, 1);
    check("frame2_last_count", last_cnt - last_base, 1);
    check("frame2_no_overflow", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
